// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath multiply/divide unit.
//   - op encodings for muldiv_unit.op
//   - md_state_t: iterative multiply/divide FSM states
package cpu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of the multiply/divide datapath on magnitudes.
// Ports:
//   mode_i  0 = shift-add multiply step, 1 = restoring divide step
//   acc_i   partial product high half / partial remainder
//   q_i     multiplier bits (shifting right) / dividend-quotient bits (shifting left)
//   opnd_i  multiplicand / divisor magnitude
//   acc_o   next accumulator
//   q_o     next q register
module muldiv_iter_step #(
  parameter int DWIDTH = 32
) (
  input  logic              mode_i,
  input  logic [DWIDTH-1:0] acc_i,
  input  logic [DWIDTH-1:0] q_i,
  input  logic [DWIDTH-1:0] opnd_i,
  output logic [DWIDTH-1:0] acc_o,
  output logic [DWIDTH-1:0] q_o
);

  logic [DWIDTH:0] sum;
  logic [DWIDTH:0] sh;
  logic [DWIDTH:0] diff;

  always_comb begin
    // Multiply: add multiplicand when the low multiplier bit is set, then
    // shift {carry, acc, q} right by one; the sum's LSB enters q from the top.
    sum  = {1'b0, acc_i} + (q_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: bring the next dividend bit into the remainder and trial-subtract.
    // The remainder stays below the divisor, so bit DWIDTH of diff is a clean
    // borrow flag.
    sh   = {acc_i, q_i[DWIDTH-1]};
    diff = sh - {1'b0, opnd_i};
    if (mode_i) begin
      if (!diff[DWIDTH]) begin
        acc_o = diff[DWIDTH-1:0];
        q_o   = {q_i[DWIDTH-2:0], 1'b1};
      end else begin
        acc_o = sh[DWIDTH-1:0];
        q_o   = {q_i[DWIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[DWIDTH:1];
      q_o   = {sum[0], q_i[DWIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO architectural registers.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   start   launch op (honoured only when busy=0)
//   op      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6..7 no-op
//   in_a    rs operand (multiplicand / dividend / MTHI-MTLO data)
//   in_b    rt operand (multiplier / divisor)
//   cancel  abort an in-flight MULT/DIV; also blocks a start in the same cycle
//   busy    MULT/DIV in progress
//   done    one-cycle pulse, hi/lo updated on the same edge
//   hi, lo  HI/LO registers
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = $clog2(DWIDTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] hi,
  output logic [DWIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DWIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [DWIDTH-1:0] cond_neg(input logic [DWIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DWIDTH-1:0] cond_neg2(input logic [2*DWIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  md_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DWIDTH-1:0] hi_q, hi_d;
  logic [DWIDTH-1:0] lo_q, lo_d;

  // Operation datapath state (no reset: only meaningful while busy)
  logic [DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0] qr_q, qr_d;
  logic [DWIDTH-1:0] opnd_q, opnd_d;
  logic [DWIDTH-1:0] a_q, a_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;

  logic [DWIDTH-1:0] step_acc;
  logic [DWIDTH-1:0] step_q;
  logic              sgn;
  logic              a_neg;
  logic              b_neg;

  muldiv_iter_step #(
    .DWIDTH (DWIDTH)
  ) u_step (
    .mode_i (is_div_q),
    .acc_i  (acc_q),
    .q_i    (qr_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .q_o    (step_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    sgn      = (op == MD_MULT) || (op == MD_DIV);
    a_neg    = sgn & in_a[DWIDTH-1];
    b_neg    = sgn & in_b[DWIDTH-1];

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !cancel) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d  = CALC;
              cnt_d    = CNT_INIT;
              busy_d   = 1'b1;
              acc_d    = '0;
              qr_d     = cond_neg(in_a, a_neg);
              opnd_d   = cond_neg(in_b, b_neg);
              a_d      = in_a;
              is_div_d = op[1];
              neg_d    = a_neg ^ b_neg;
              rneg_d   = a_neg;
              dz_d     = (in_b == '0);
            end
            MD_MTHI: hi_d = in_a;
            MD_MTLO: lo_d = in_a;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = step_acc;
          qr_d  = step_q;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = cond_neg2({acc_q, qr_q}, neg_q);
          end else if (dz_q) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            // Quotient sign is sign(a)^sign(b); remainder follows the dividend.
            lo_d = cond_neg(qr_q, neg_q);
            hi_d = cond_neg(acc_q, rneg_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    qr_q     <= qr_d;
    opnd_q   <= opnd_d;
    a_q      <= a_d;
    is_div_q <= is_div_d;
    neg_q    <= neg_d;
    rneg_q   <= rneg_d;
    dz_q     <= dz_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         cancel = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int nvec = 0;
  int nerr = 0;

  muldiv_unit #(.DWIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .in_a   (in_a),
    .in_b   (in_b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for the done pulse; returns edges counted after the start edge.
  task automatic wait_done(output int lat, output bit busy_ok);
    bit got;
    got = 0;
    lat = 0;
    busy_ok = 1;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
      else if (!busy) busy_ok = 0;
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat;
    bit bok;
    start = 1'b1; op = o; in_a = a; in_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy_rise"}, 64'(busy), 64'd1);
    wait_done(lat, bok);
    chk({nm, " latency"}, 64'(lat), 64'd33);
    chk({nm, " busy_held"}, 64'(bok), 64'd1);
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int lat;
    bit bok;
    int npulse;

    vt[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[1] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vt[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
    vt[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[5] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[6] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vt[7] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[8] = '{3'd1, 32'h00010000, 32'h00030000, 32'h00000003, 32'h00000000};
    vt[9] = '{3'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};

    // Reset state
    #12;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Table vectors, back-to-back (next start issued in the done cycle)
    for (int i = 0; i < NV; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);
    end

    // MTHI: one edge, no busy
    start = 1'b1; op = 3'd4; in_a = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi hi", 64'(hi), 64'h1234);
    chk("mthi lo_hold", 64'(lo), 64'(vt[NV-1].lo));
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);

    // MULTU 3x4 with an MTLO start pulsed mid-CALC
    start = 1'b1; op = 3'd1; in_a = 32'd3; in_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = 3'd5; in_a = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0;
    chk("midstart hi", 64'(hi), 64'h1234);
    chk("midstart lo", 64'(lo), 64'(vt[NV-1].lo));
    chk("midstart busy", 64'(busy), 64'd1);
    wait_done(lat, bok);
    chk("midstart latency", 64'(lat + 5), 64'd33);
    chk("midstart busy_held", 64'(bok), 64'd1);
    chk("midstart res hi", 64'(hi), 64'd0);
    chk("midstart res lo", 64'(lo), 64'd12);

    // MULT 6x7 cancelled mid-CALC
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; in_a = 32'd6; in_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel busy", 64'(busy), 64'd0);
    chk("cancel done", 64'(done), 64'd0);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) npulse++;
    end
    chk("cancel no_done", 64'(npulse), 64'd0);
    chk("cancel hi", 64'(hi), 64'd0);
    chk("cancel lo", 64'(lo), 64'd12);
    do_op("divu_after_cancel", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    // cancel together with start in IDLE: nothing launches
    start = 1'b1; cancel = 1'b1; op = 3'd0; in_a = 32'd2; in_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start busy", 64'(busy), 64'd0);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) npulse++;
    end
    chk("cancel_start idle", 64'(npulse), 64'd0);
    chk("cancel_start hi", 64'(hi), 64'd2);
    chk("cancel_start lo", 64'(lo), 64'd14);

    // op 6 is a no-op
    start = 1'b1; op = 3'd6; in_a = 32'hFFFF; in_b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("op6 busy", 64'(busy), 64'd0);
    chk("op6 hi", 64'(hi), 64'd2);
    chk("op6 lo", 64'(lo), 64'd14);

    // Asynchronous reset mid-CALC
    start = 1'b1; op = 3'd1; in_a = 32'd5; in_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst busy", 64'(busy), 64'd0);
    chk("async_rst done", 64'(done), 64'd0);
    chk("async_rst hi", 64'(hi), 64'd0);
    chk("async_rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; in_a = 32'hA5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_rst mtlo lo", 64'(lo), 64'hA5);
    chk("post_rst mtlo hi", 64'(hi), 64'd0);
    chk("post_rst mtlo busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO architectural registers for the CPU datapath.
- Generalises the existing single-cycle multiplier in four ways: parametrised width, signed and unsigned MULT and DIV, MTHI/MTLO writes, and a start/busy/done handshake with cancel.
- Sits beside the ALU. The datapath feeds it rs/rt operands and stalls any mfhi/mflo while busy=1.

Parameters:
- DWIDTH, 32, operand and HI/LO width (≥4).
- CNT_W, $clog2(DWIDTH)+1, iteration counter width. Derived; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  launch the operation on op; honoured only when busy=0
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6..7=no-op
- in_a  input  DWIDTH  rs: multiplicand/dividend, or MTHI/MTLO data
- in_b  input  DWIDTH  rt: multiplier/divisor
- cancel  input  1  abort the in-flight MULT/DIV (exception flush)
- busy  output  1  MULT/DIV in progress
- done  output  1  one-cycle pulse; hi/lo updated on the same edge
- hi  output  DWIDTH  HI register
- lo  output  DWIDTH  LO register

Behaviour:
- Reset (async, reset=0): state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0. Takes effect immediately, including mid-operation.
- FSM states:
  - IDLE: start with op 0..3 → latch operands → CALC with counter=DWIDTH.
  - CALC: one iteration per cycle; counter decrements; at counter==1 → FIX.
  - FIX: sign correction; write hi/lo; done=1 → IDLE.
- busy=1 in CALC and FIX. busy is registered, so it rises on the edge that accepts start.
- Latency: start sampled at edge 0 → done high and hi/lo valid after edge DWIDTH+1 (33 at DWIDTH=32). Back-to-back start is accepted the cycle done is high (state is IDLE).
- MTHI/MTLO (op 4/5) with start and busy=0: hi (resp. lo) ← in_a on the next edge. 1-cycle; no busy; no done.
- start while busy=1: ignored, with no effect on state, hi or lo. op 6..7: ignored.
- Multiply:
  - Shift-add on magnitudes. For MULT, operands are made absolute in IDLE→CALC.
  - Product negated in FIX if sign(a)^sign(b).
  - {hi,lo} = full 2·DWIDTH product. MULTU treats operands as unsigned.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - FIX applies signs: quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend.
  - lo=quotient, hi=remainder.
- Divide by zero (in_b==0, signed or unsigned): runs full latency; lo=all-ones, hi=in_a as latched.
- Signed overflow (most-negative / −1): lo=most-negative, hi=0. Wrap, no trap.
- cancel:
  - In CALC/FIX: → IDLE next edge; busy=0; done=0; hi/lo unchanged.
  - cancel and start together in IDLE: cancel wins; nothing launches.
  - Has no effect on an MTHI/MTLO already written.
- hi/lo hold their value at all times except on the done edge or an MTHI/MTLO write. No partial results are visible.

Decomposition:
- Shared package (cpu_pkg):
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  - FSM state typedef md_state_t {IDLE, CALC, FIX}
- One natural sub-module: muldiv_iter_step.
  - Combinational single iteration: add-shift or subtract-compare on {acc, operand}, selected by a mode bit.
  - Instantiated once; the FSM and sign handling stay in muldiv_unit.

Test Plan (DWIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done after 33 edges; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0x00000000.
- MTHI in_a=0x1234 → hi=0x1234 after one edge, busy stays 0. Then MULTU 3×4 with a second start (op=MTLO) pulsed mid-CALC → the second start is ignored; final hi=0, lo=12.
- MULT 6×7, cancel asserted at cycle 10 → busy=0 next edge, no done pulse, hi/lo keep their prior values. An immediate new DIVU 100/7 completes with lo=14, hi=2.
- reset driven low mid-CALC (asynchronous, between edges) → busy, done, hi, lo go to 0 without waiting for a clock edge. After release, MTLO 0xA5 → lo=0xA5.
